acc_cmd_input: RTL and testbench

//  - Upstream stage of the accumulator datapath: turns 9 raw push-button lines into the 9-bit one-hot command bus consumed by the accumulator's encoder/enable FSM.
//  - Synchronises, debounces and edge-detects the buttons; emits exactly one single-cycle one-hot pulse per accepted press.
//  - One button is serviced at a time; all others are ignored until the active one is released and debounced.

---
 rtl/acc_pkg.sv | 14 +
 rtl/acc_cmd_input_btn_sync.sv | 22 ++
 rtl/acc_cmd_input.sv | 88 ++++++++
 tb/tb_acc_cmd_input.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared command-bus width, FSM state encoding and one-hot helpers for the accumulator input stage.
package acc_pkg;
  localparam int N_BTN = 9;
  localparam int SEL_W = $clog2(N_BTN);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, FIRE, HELD, DEB_REL} state_t;
  function automatic logic [SEL_W-1:0] lowest_set_index(input logic [N_BTN-1:0] v);
    lowest_set_index = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (v[i]) lowest_set_index = SEL_W'(i);
  endfunction
  function automatic logic [N_BTN-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = {{(N_BTN-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/acc_cmd_input_btn_sync.sv
// btn_sync: W-bit two-flop synchroniser for asynchronous button levels, sync active-low clear.
module btn_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_q = r_s2;
endmodule

// File: rtl/acc_cmd_input.sv
// acc_cmd_input: debounced single-pulse one-hot command generator for 9 push buttons.
// Optional held-button auto-repeat is enabled by defining ACC_AUTO_REPEAT_EN.
module acc_cmd_input
  import acc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] cmd,
  output logic             busy
);
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  logic [N_BTN-1:0] w_bs;
  logic             w_hit;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic [N_BTN-1:0] r_cmd;
  btn_sync #(.W(N_BTN)) u_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .i_d   (btn),
    .o_q   (w_bs)
  );
  assign w_hit = w_bs[r_sel];
  // cmd is loaded on the edge entering FIRE so it is high exactly while state==FIRE
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_cmd   <= '0;
    end else begin
      r_cmd <= '0;
      case (r_state)
        IDLE:
          if (|w_bs) begin
            r_sel   <= lowest_set_index(w_bs);
            r_cnt   <= '0;
            r_state <= DEB_PRESS;
          end
        DEB_PRESS:
          if (!w_hit) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_state <= FIRE;
            r_cnt   <= '0;
            r_cmd   <= onehot(r_sel);
          end else r_cnt <= r_cnt + CNT_W'(1);
        FIRE: begin
          r_state <= HELD;
          r_cnt   <= '0;
        end
        HELD:
          if (!w_hit) begin
            r_state <= DEB_REL;
            r_cnt   <= '0;
          end
`ifdef ACC_AUTO_REPEAT_EN
          else if (r_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
            r_state <= FIRE;
            r_cnt   <= '0;
            r_cmd   <= onehot(r_sel);
          end else r_cnt <= r_cnt + CNT_W'(1);
`endif
        DEB_REL:
          if (w_hit) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else r_cnt <= r_cnt + CNT_W'(1);
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
  assign cmd  = r_cmd;
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_acc_cmd_input.sv
// tb_acc_cmd_input: directed tests of debounce, priority, bounce rejection, reset and auto-repeat timing.
module tb_acc_cmd_input;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [8:0] btn = '0;
  logic [8:0] cmd;
  logic       busy;
  int total = 0;
  int bad = 0;
`ifdef ACC_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  acc_cmd_input #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (btn),
    .cmd   (cmd),
    .busy  (busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic settle(input int n);
    btn = '0;
    repeat (n) step();
  endtask
  task automatic test_reset();
    clr_n = 1'b0;
    btn = 9'h1FF;
    repeat (3) step();
    total++; if (cmd !== 9'h000) begin bad++; $display("FAIL reset_cmd got=%h exp=000", cmd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    btn = '0;
    clr_n = 1'b1;
    repeat (3) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask
  task automatic test_single();
    logic [8:0] e;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) btn = 9'h004;
      step();
      e = (c == 7 || (REP && c > 7 && (c - 7) % 9 == 0)) ? 9'h004 : 9'h000;
      total++; if (cmd !== e) begin bad++; $display("FAIL single_cmd c=%0d got=%h exp=%h", c, cmd, e); end
      total++; if (busy !== (c >= 3)) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, c >= 3); end
    end
    btn = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++; if (cmd !== 9'h000) begin bad++; $display("FAIL single_rel_cmd c=%0d got=%h exp=000", c, cmd); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_rel_busy got=%b exp=0", busy); end
  endtask
  task automatic test_glitch();
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) btn = 9'h001;
      if (c == 3) btn = 9'h000;
      step();
      total++; if (cmd !== 9'h000) begin bad++; $display("FAIL glitch_cmd c=%0d got=%h exp=000", c, cmd); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask
  task automatic test_priority();
    logic [8:0] e;
    for (int c = 1; c <= 26; c++) begin
      if (c == 1) btn = 9'h011;
      if (c == 11) btn = 9'h010;
      step();
      e = (c == 7) ? 9'h001 : (c == 22) ? 9'h010 : 9'h000;
      total++; if (cmd !== e) begin bad++; $display("FAIL prio_cmd c=%0d got=%h exp=%h", c, cmd, e); end
    end
    btn = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++; if (cmd !== 9'h000) begin bad++; $display("FAIL prio_rel_cmd c=%0d got=%h exp=000", c, cmd); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_busy got=%b exp=0", busy); end
  endtask
  task automatic test_bounce();
    logic [8:0] e;
    for (int c = 1; c <= 22; c++) begin
      if (c == 1) btn = 9'h008;
      if (c >= 10 && c <= 15) btn = (c % 2 == 0) ? 9'h000 : 9'h008;
      step();
      e = (c == 7) ? 9'h008 : 9'h000;
      total++; if (cmd !== e) begin bad++; $display("FAIL bounce_cmd c=%0d got=%h exp=%h", c, cmd, e); end
      total++; if (busy !== (c >= 3)) begin bad++; $display("FAIL bounce_busy c=%0d got=%b exp=%b", c, busy, c >= 3); end
    end
    btn = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++; if (cmd !== 9'h000) begin bad++; $display("FAIL bounce_rel_cmd c=%0d got=%h exp=000", c, cmd); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bounce_end_busy got=%b exp=0", busy); end
  endtask
  task automatic test_reset_mid();
    logic [8:0] e;
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) btn = 9'h002;
      if (c == 5) clr_n = 1'b0;
      if (c == 6) clr_n = 1'b1;
      step();
      e = (c == 12) ? 9'h002 : 9'h000;
      total++; if (cmd !== e) begin bad++; $display("FAIL rst_deb_cmd c=%0d got=%h exp=%h", c, cmd, e); end
      if (c >= 5) begin
        total++; if (busy !== (c >= 8)) begin bad++; $display("FAIL rst_deb_busy c=%0d got=%b exp=%b", c, busy, c >= 8); end
      end
    end
    settle(12);
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) btn = 9'h002;
      if (c == 8) clr_n = 1'b0;
      if (c == 9) begin clr_n = 1'b1; btn = 9'h000; end
      step();
      e = (c == 7) ? 9'h002 : 9'h000;
      total++; if (cmd !== e) begin bad++; $display("FAIL rst_fire_cmd c=%0d got=%h exp=%h", c, cmd, e); end
      if (c >= 8) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_fire_busy c=%0d got=%b exp=0", c, busy); end
      end
    end
  endtask
  task automatic test_repeat();
    logic [8:0] e;
    int pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) btn = 9'h100;
      step();
      e = (c == 7 || (REP && c > 7 && (c - 7) % 9 == 0)) ? 9'h100 : 9'h000;
      if (cmd !== 9'h000) pulses++;
      total++; if (cmd !== e) begin bad++; $display("FAIL repeat_cmd c=%0d got=%h exp=%h", c, cmd, e); end
    end
    total++; if (pulses !== (REP ? 4 : 1)) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", pulses, REP ? 4 : 1); end
    btn = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++; if (cmd !== 9'h000) begin bad++; $display("FAIL repeat_rel_cmd c=%0d got=%h exp=000", c, cmd); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL repeat_busy got=%b exp=0", busy); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    settle(4);
    test_glitch();
    settle(4);
    test_priority();
    settle(4);
    test_bounce();
    settle(4);
    test_reset_mid();
    settle(4);
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
